// File: rtl/multi_debounce_filter.sv
// N-channel debouncer: per-channel synchroniser, counter-based filter, registered rise/fall pulses.
// Optional long-press detector (o_Held) is compiled in when LONG_PRESS_EN is defined.
module multi_debounce_filter #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned INIT_LEVEL     = 0,
  parameter int unsigned HOLD_LIMIT     = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change,
  output logic [NUM_CH-1:0] o_Held
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [NUM_CH-1:0] RST_VEC  = {NUM_CH{1'(INIT_LEVEL)}};

  // Reject configurations the filter cannot implement.
  if (NUM_CH < 1 || DEBOUNCE_LIMIT < 1 || SYNC_STAGES < 2 || INIT_LEVEL > 1 || HOLD_LIMIT < 1) begin : g_bad_cfg
    $error("multi_debounce_filter: illegal parameter combination");
  end

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;

  // Metastability synchroniser chain; only the last stage feeds the filter.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RST_VEC;
    end else begin
      sync_q[0] <= i_Bouncy;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] state_d;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_d;

  // Any agreement with the current state discards the run; the state flips on the LIMIT-th differing sample.
  always_comb begin
    state_d = o_Debounced;
    for (int k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (s[k] != o_Debounced[k]) begin
        if (cnt_q[k] == CNT_LAST) state_d[k] = s[k];
        else                      cnt_d[k]   = cnt_q[k] + CNT_W'(1);
      end
    end
    rise_d = state_d & ~o_Debounced;
    fall_d = ~state_d & o_Debounced;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Debounced  <= RST_VEC;
      o_Rise       <= '0;
      o_Fall       <= '0;
      o_Any_Change <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      o_Debounced  <= state_d;
      o_Rise       <= rise_d;
      o_Fall       <= fall_d;
      o_Any_Change <= |(rise_d | fall_d);
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned      HOLD_W   = $clog2(HOLD_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [HOLD_W-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0] held_d;

  // Counting starts the cycle after the rise edge; clearing uses the next state so o_Held drops with o_Fall.
  always_comb begin
    held_d = '0;
    for (int k = 0; k < NUM_CH; k++) hold_d[k] = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_d[k]) begin
        hold_d[k] = hold_q[k];
        if (o_Debounced[k] && hold_q[k] != HOLD_MAX) hold_d[k] = hold_q[k] + HOLD_W'(1);
      end
      held_d[k] = (hold_d[k] == HOLD_MAX);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Held <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      o_Held <= held_d;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= hold_d[k];
    end
  end
`else
  assign o_Held = '0;
`endif

endmodule

// File: tb/tb_multi_debounce_filter.sv
// Directed bench for multi_debounce_filter (NUM_CH=2, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, HOLD_LIMIT=8).
module tb_multi_debounce_filter;

`ifdef LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [1:0] i_Bouncy;
  logic [1:0] o_Debounced, o_Rise, o_Fall, o_Held;
  logic       o_Any_Change;

  int n_cmp = 0;
  int n_err = 0;

  multi_debounce_filter #(
    .NUM_CH(2), .DEBOUNCE_LIMIT(4), .SYNC_STAGES(2), .INIT_LEVEL(0), .HOLD_LIMIT(8)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Bouncy(i_Bouncy),
    .o_Debounced(o_Debounced), .o_Rise(o_Rise), .o_Fall(o_Fall),
    .o_Any_Change(o_Any_Change), .o_Held(o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] sticky_ev, sticky_deb, sticky_held;

  initial begin
    i_Reset  = 1'b1;
    i_Bouncy = 2'b00;
    tick(); tick();
    chk("rst_deb",  8'(o_Debounced), 8'h0);
    chk("rst_rise", 8'(o_Rise), 8'h0);
    chk("rst_fall", 8'(o_Fall), 8'h0);
    chk("rst_any",  8'(o_Any_Change), 8'h0);
    chk("rst_held", 8'(o_Held), 8'h0);
    i_Reset = 1'b0;
    tick(); tick();
    chk("rst_exit_any", 8'(o_Any_Change), 8'h0);

    // Clean step on ch0: flip after N+6.
    i_Bouncy = 2'b01;
    sticky_ev = '0; sticky_deb = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      sticky_ev  |= o_Rise | o_Fall;
      sticky_deb |= o_Debounced;
    end
    chk("step_early_deb", 8'(sticky_deb), 8'h0);
    chk("step_early_ev",  8'(sticky_ev), 8'h0);
    tick();
    chk("step_deb",  8'(o_Debounced), 8'h1);
    chk("step_rise", 8'(o_Rise), 8'h1);
    chk("step_fall", 8'(o_Fall), 8'h0);
    chk("step_any",  8'(o_Any_Change), 8'h1);
    tick();
    chk("step_rise_1cyc", 8'(o_Rise), 8'h0);
    chk("step_any_1cyc",  8'(o_Any_Change), 8'h0);
    chk("step_deb_hold",  8'(o_Debounced), 8'h1);

    i_Bouncy = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("back_low_deb", 8'(o_Debounced), 8'h0);

    // Glitch: high 1, low 1, then steady high; flip only after M+8.
    i_Bouncy = 2'b01; tick();
    i_Bouncy = 2'b00; tick();
    i_Bouncy = 2'b01;
    sticky_ev = '0; sticky_deb = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      sticky_ev  |= o_Rise | o_Fall;
      sticky_deb |= o_Debounced;
    end
    chk("glitch_no_flip", 8'(sticky_deb), 8'h0);
    chk("glitch_no_ev",   8'(sticky_ev), 8'h0);
    tick();
    chk("glitch_deb", 8'(o_Debounced), 8'h1);
    chk("glitch_rise", 8'(o_Rise), 8'h1);

    i_Bouncy = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("back_low2_deb", 8'(o_Debounced), 8'h0);

    // Three high samples then low: no flip, no pulse.
    i_Bouncy = 2'b01; tick(); tick(); tick();
    i_Bouncy = 2'b00;
    sticky_ev = '0; sticky_deb = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sticky_ev  |= o_Rise | o_Fall;
      sticky_deb |= o_Debounced;
    end
    chk("short_no_flip", 8'(sticky_deb), 8'h0);
    chk("short_no_ev",   8'(sticky_ev), 8'h0);

    // Counter must have returned to 0: full latency again.
    i_Bouncy = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    chk("short_reload_early", 8'(o_Debounced), 8'h0);
    tick();
    chk("short_reload_deb", 8'(o_Debounced), 8'h1);

    // Both channels high, then both fall on the same edge.
    i_Bouncy = 2'b11;
    for (int i = 0; i < 8; i++) tick();
    chk("both_high", 8'(o_Debounced), 8'h3);
    i_Bouncy = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    chk("both_fall_early", 8'(o_Fall), 8'h0);
    tick();
    chk("both_fall", 8'(o_Fall), 8'h3);
    chk("both_fall_rise", 8'(o_Rise), 8'h0);
    chk("both_fall_any", 8'(o_Any_Change), 8'h1);
    chk("both_fall_deb", 8'(o_Debounced), 8'h0);
    tick();
    chk("both_fall_1cyc", 8'(o_Fall), 8'h0);
    chk("both_any_1cyc", 8'(o_Any_Change), 8'h0);

    // Reset when ch0 count==2: partial count discarded.
    i_Bouncy = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    chk("midrst_deb", 8'(o_Debounced), 8'h0);
    chk("midrst_rise", 8'(o_Rise), 8'h0);
    sticky_ev = '0; sticky_deb = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      sticky_ev  |= o_Rise;
      sticky_deb |= o_Debounced;
    end
    chk("midrst_no_early_flip", 8'(sticky_deb), 8'h0);
    chk("midrst_no_early_rise", 8'(sticky_ev), 8'h0);
    tick();
    chk("midrst_deb_flip", 8'(o_Debounced), 8'h1);
    chk("midrst_rise_flip", 8'(o_Rise), 8'h1);

    // Long press: o_Held 8 cycles after the rise edge, drops with o_Fall.
    sticky_held = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      sticky_held |= o_Held;
    end
    chk("held_early", 8'(sticky_held), 8'h0);
    tick();
    chk("held_on", 8'(o_Held), LP ? 8'h1 : 8'h0);
    tick(); tick(); tick();
    chk("held_stays", 8'(o_Held), LP ? 8'h1 : 8'h0);
    i_Bouncy = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    chk("held_before_fall", 8'(o_Held), LP ? 8'h1 : 8'h0);
    tick();
    chk("held_fall_pulse", 8'(o_Fall), 8'h1);
    chk("held_off", 8'(o_Held), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debounce_filter.md
Name: multi_debounce_filter

Overview:
- Parametrised N-channel debouncer. Successor to the single-bit debounce filter.
- Adds per-channel metastability synchronisers, a configurable reset level, and one-cycle rise/fall event pulses. A compile-time long-press detector is optional.
- Sits between raw board inputs (buttons, switches) and the control logic that consumes clean levels and edge events.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive cycles an input must differ from the current debounced state before the state flips (>=1). The default is 10 ms at 25 MHz.
- SYNC_STAGES, 2, flip-flop depth of the per-channel input synchroniser (>=2).
- INIT_LEVEL, 0, reset value of every channel's debounced state and synchroniser flops (0 or 1).
- HOLD_LIMIT, 25000000, cycles of continuous high debounced state before o_Held asserts. Used only with LONG_PRESS_EN.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Bouncy  in  NUM_CH  raw asynchronous inputs, one bit per channel.
- o_Debounced  out  NUM_CH  clean registered levels.
- o_Rise  out  NUM_CH  one-cycle pulse when the channel's debounced level goes 0->1.
- o_Fall  out  NUM_CH  one-cycle pulse when the channel's debounced level goes 1->0.
- o_Any_Change  out  1  OR-reduction of o_Rise|o_Fall, registered in the same cycle as the pulses.
- o_Held  out  NUM_CH  long-press level (see Optional Feature).

Behaviour:
- Interface: one clock, i_Clk. Reset i_Reset is synchronous and active-high.
- Reset, sampled on an i_Clk edge:
  - synchroniser flops = INIT_LEVEL
  - o_Debounced = {NUM_CH{INIT_LEVEL}}
  - all counters = 0
  - o_Rise = o_Fall = o_Any_Change = 0
  - o_Held = 0
- Reset has priority over all other activity. Asserting it mid-count discards any partial count. No events are generated on reset exit.
- Synchroniser: i_Bouncy[k] passes through SYNC_STAGES flops. Call the last stage s[k]. No logic reads earlier stages.
- Counter width is $clog2(DEBOUNCE_LIMIT+1) bits, and each channel has its own counter. Per channel, on each edge:
  - s == state: count <= 0. Any difference shorter than LIMIT cycles is discarded entirely, with no partial credit.
  - s != state and count < DEBOUNCE_LIMIT-1: count <= count+1.
  - s != state and count == DEBOUNCE_LIMIT-1: state <= s, count <= 0, and the matching o_Rise/o_Fall bit is 1 for exactly this next cycle.
- Latency:
  - A clean step on i_Bouncy applied just after edge N appears on o_Debounced after edge N+SYNC_STAGES+DEBOUNCE_LIMIT.
  - o_Rise/o_Fall assert on that same edge.
- DEBOUNCE_LIMIT=1: the state follows s with one-cycle delay, and the counter never leaves 0.
- o_Rise and o_Fall are never both high on one channel. Different channels may pulse in the same cycle. o_Any_Change is 1 if any bit of either is 1.
- Channels are fully independent; no shared counter.
- Pulses are registered, not derived combinationally from the state.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Each channel has a saturating hold counter, width $clog2(HOLD_LIMIT+1).
  - The counter clears whenever the debounced state is 0. It increments each cycle the state is 1, until it reaches HOLD_LIMIT.
  - o_Held[k] = 1 while the count == HOLD_LIMIT. It asserts HOLD_LIMIT cycles after the o_Rise pulse edge.
  - o_Held[k] drops on the same edge that o_Fall[k] pulses.
- Not defined: no hold counters are instantiated, and o_Held is tied to 0.

Test Plan:
- Params NUM_CH=2, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, INIT_LEVEL=0. Hold i_Reset for 2 cycles, then drive ch0 0->1 after edge N and keep it stable -> o_Debounced[0]=1 after edge N+6; o_Rise[0]=1 and o_Any_Change=1 for exactly one cycle; ch1 unchanged.
- ch0 high for 1 cycle, low for 1 cycle, then high steadily (glitch) -> no transition until 4 consecutive high samples at s; no spurious o_Rise/o_Fall.
- ch0 high for 3 cycles then low (just under the limit) -> o_Debounced[0] stays 0, counter returns to 0, zero pulses.
- Both channels stepped 1->0 on the same edge, from a debounced-high state -> o_Fall=2'b11 in one cycle; o_Any_Change=1 for one cycle.
- Assert i_Reset when ch0's count==2 while its input differs -> state stays INIT_LEVEL. After release, a full 4-sample run is again required before a flip.
- Build with LONG_PRESS_EN, HOLD_LIMIT=8. ch0 held high -> o_Held[0]=1 eight cycles after the o_Rise[0] edge. Release -> o_Held[0]=0 on the o_Fall[0] edge. Without the macro, o_Held stays 0.
